// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the 16-bit processor: fetch/decode/exec/mem/wb sequencing.
// Optional performance counters are built when MC_CTRL_PERF_EN is defined.
module mc_ctrl #(
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic        halted,
  output logic [15:0] cyc_cnt,
  output logic [15:0] ins_cnt
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQ  = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;

  state_t     state_q, state_d;
  logic [3:0] opc_q, opc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opc_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
    end
  end

  // Handshake-qualified strobes (ir_we/pc_we in FETCH, taken BEQ) follow
  // mem_ready/alu_zero directly so they coincide with the completing cycle.
  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_sel     = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          opc_d   = opcode;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opc_q == HALT_OP) state_d = S_HALT;
        else if (opc_q == OP_JMP) begin
          pc_we   = 1'b1;
          pc_sel  = 2'b10;
          state_d = S_FETCH;
        end else if (opc_q <= OP_BEQ) state_d = S_EXEC;
        else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        if (opc_q == OP_BEQ) begin
          alu_op  = 2'b01;
          state_d = S_FETCH;
          if (alu_zero) begin
            pc_we  = 1'b1;
            pc_sel = 2'b01;
          end
        end else if (opc_q >= OP_ADDI) begin
          alu_src = 1'b1;
          state_d = (opc_q == OP_ADDI) ? S_WB : S_MEM;
        end else begin
          alu_op  = opc_q[1:0];
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (opc_q == OP_SW);
        if (mem_ready) state_d = (opc_q == OP_SW) ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = (opc_q == OP_LW);
        state_d    = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  logic [15:0] cyc_q, cyc_d, ins_q, ins_d;
  logic        active, retire;

  always_comb begin
    active = (state_q != S_IDLE) && (state_q != S_HALT);
    retire = (state_d == S_FETCH) &&
             (state_q == S_DECODE || state_q == S_EXEC ||
              state_q == S_MEM    || state_q == S_WB);
    cyc_d  = active ? cyc_q + 16'd1 : cyc_q;
    ins_d  = retire ? ins_q + 16'd1 : ins_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= 16'd0;
      ins_q <= 16'd0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ins_cnt = ins_q;
`else
  assign cyc_cnt = 16'd0;
  assign ins_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: an instruction-level model expands each opcode into
// its expected per-cycle control trace, which is compared against the DUT.
module tb_mc_ctrl;
`ifdef MC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, rst_n, run, alu_zero, mem_ready;
  logic [3:0]  opcode;
  logic        mem_req, mem_we, ir_we, pc_we, alu_src, reg_we, mem_to_reg, illegal, halted;
  logic [1:0]  pc_sel, alu_op;
  logic [15:0] cyc_cnt, ins_cnt;

  mc_ctrl #(.HALT_OP(4'hF)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .alu_src(alu_src), .alu_op(alu_op),
    .reg_we(reg_we), .mem_to_reg(mem_to_reg), .illegal(illegal), .halted(halted),
    .cyc_cnt(cyc_cnt), .ins_cnt(ins_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        zro;
    logic [12:0] exp;
  } step_t;

  step_t q[$];
  int    n_chk = 0, n_fail = 0;
  int    exp_cyc = 0, exp_ins = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] mk(bit req, bit we, bit ir, bit pcw, bit [1:0] psel,
                                     bit asrc, bit [1:0] aop, bit rwe, bit m2r,
                                     bit ill, bit hlt);
    return {req, we, ir, pcw, psel, asrc, aop, rwe, m2r, ill, hlt};
  endfunction

  function automatic logic [12:0] outs();
    return {mem_req, mem_we, ir_we, pc_we, pc_sel, alu_src, alu_op,
            reg_we, mem_to_reg, illegal, halted};
  endfunction

  // Called at posedge+1; drives inputs, checks at the falling edge, returns at posedge+1.
  task automatic cyc(input logic rdy, input logic zro, input logic [12:0] exp, input string tag);
    mem_ready = rdy;
    alu_zero  = zro;
    @(negedge clk);
    chk(tag, {19'd0, outs()}, {19'd0, exp});
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  // Expected control trace of one instruction, from fetch to the edge into the next fetch.
  task automatic build(input logic [3:0] op, input int fw, input int mw, input logic az);
    q.delete();
    for (int i = 0; i < fw; i++) q.push_back('{1'b0, rb(), mk(1,0,0,0,0,0,0,0,0,0,0)});
    q.push_back('{1'b1, rb(), mk(1,0,1,1,0,0,0,0,0,0,0)});
    if (op == 4'hF)      q.push_back('{rb(), rb(), 13'd0});
    else if (op == 4'd8) q.push_back('{rb(), rb(), mk(0,0,0,1,2'b10,0,0,0,0,0,0)});
    else if (op > 4'd8)  q.push_back('{rb(), rb(), mk(0,0,0,0,0,0,0,0,0,1,0)});
    else begin
      q.push_back('{rb(), rb(), 13'd0});
      if (op <= 4'd3) begin
        q.push_back('{rb(), rb(), mk(0,0,0,0,0,0,op[1:0],0,0,0,0)});
        q.push_back('{rb(), rb(), mk(0,0,0,0,0,0,0,1,0,0,0)});
      end else if (op == 4'd7) begin
        q.push_back('{rb(), az, mk(0,0,0,az,az ? 2'b01 : 2'b00,0,2'b01,0,0,0,0)});
      end else begin
        q.push_back('{rb(), rb(), mk(0,0,0,0,0,1,0,0,0,0,0)});
        if (op == 4'd4) q.push_back('{rb(), rb(), mk(0,0,0,0,0,0,0,1,0,0,0)});
        else begin
          for (int i = 0; i < mw; i++)
            q.push_back('{1'b0, rb(), mk(1,op == 4'd6,0,0,0,0,0,0,0,0,0)});
          q.push_back('{1'b1, rb(), mk(1,op == 4'd6,0,0,0,0,0,0,0,0,0)});
          if (op == 4'd5) q.push_back('{rb(), rb(), mk(0,0,0,0,0,0,0,1,1,0,0)});
        end
      end
    end
  endtask

  task automatic play(input logic [3:0] op, input int fw, input int mw, input logic az);
    string tag;
    build(op, fw, mw, az);
    opcode = op;
    exp_cyc += q.size();
    if (op != 4'hF) exp_ins++;
    foreach (q[i]) begin
      run = rb();
      tag = $sformatf("op%0h_c%0d", op, i + 1);
      cyc(q[i].rdy, q[i].zro, q[i].exp, tag);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cyc"}, {16'd0, cyc_cnt}, PERF ? 32'(exp_cyc & 16'hFFFF) : 32'd0);
    chk({tag, "_ins"}, {16'd0, ins_cnt}, PERF ? 32'(exp_ins & 16'hFFFF) : 32'd0);
  endtask

  initial begin
    logic [3:0] op;
    logic [3:0] ops [10];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd11};
    rst_n = 1'b0; run = 1'b0; opcode = 4'd0; alu_zero = 1'b0; mem_ready = 1'b1;
    #12;
    chk("rst_outs", {19'd0, outs()}, 32'd0);
    chk_cnt("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 13'd0, "idle_norun");
    run = 1'b1;
    cyc(1'b1, 1'b0, 13'd0, "idle_run");

    // Directed: ADD, LW with 2 waits, BEQ taken/not, ADDI, SW, JMP, illegal
    play(4'd0, 0, 0, 1'b0);
    play(4'd5, 0, 2, 1'b0);
    play(4'd7, 0, 0, 1'b1);
    play(4'd7, 1, 0, 1'b0);
    play(4'd4, 0, 0, 1'b0);
    play(4'd6, 0, 0, 1'b0);
    play(4'd8, 0, 0, 1'b0);
    play(4'hB, 0, 0, 1'b0);
    chk_cnt("directed");

    for (int n = 0; n < 60; n++) begin
      op = (n % 3 == 0) ? 4'($urandom_range(14, 9)) : ops[$urandom_range(9, 0)];
      play(op, $urandom_range(2, 0), $urandom_range(2, 0), rb());
    end
    chk_cnt("random");

    // Asynchronous reset in the middle of a fetch wait
    opcode = 4'd0; mem_ready = 1'b0;
    @(negedge clk);
    chk("fetch_wait_req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {19'd0, outs()}, 32'd0);
    exp_cyc = 0; exp_ins = 0;
    chk_cnt("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1; run = 1'b0;
    cyc(1'b1, 1'b0, 13'd0, "post_rst_idle");
    run = 1'b1;
    cyc(1'b1, 1'b0, 13'd0, "post_rst_run");

    play(4'd0, 0, 0, 1'b0);
    play(4'd0, 0, 0, 1'b0);
    play(4'd0, 0, 0, 1'b0);
    play(4'hF, 0, 0, 1'b0);
    chk("cyc14", {16'd0, cyc_cnt}, PERF ? 32'd14 : 32'd0);
    chk("ins3",  {16'd0, ins_cnt}, PERF ? 32'd3  : 32'd0);
    for (int i = 0; i < 10; i++) begin
      run = ~run;
      cyc(rb(), rb(), mk(0,0,0,0,0,0,0,0,0,0,1), $sformatf("halt_%0d", i));
    end
    chk_cnt("halt_hold");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
